// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, the operand forward select codes, and the
// EX / WB slot records that track destination registers in flight.
package hazard_pkg;

  // Architectural register address width tracked in the slots.
  localparam int unsigned SLOT_DST_W = 3;
  // Width of the multiply cycle down-counter.
  localparam int unsigned CNT_W      = 4;
  // Width of an operand forward select.
  localparam int unsigned FWD_W      = 2;

  typedef logic [SLOT_DST_W-1:0] reg_addr_t;
  typedef logic [FWD_W-1:0]      fwd_sel_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  // Operand source selects for the EX operand muxes.
  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_EX = 2'b01;
  localparam fwd_sel_t FWD_WB = 2'b10;

  // RUN: normal issue; MULW: a multiply is holding EX.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MULW = 1'b1
  } state_e;

  // Instruction occupying the EX stage.
  typedef struct packed {
    logic      v;
    reg_addr_t dst;
    logic      wr;
    logic      ld;
  } slot_t;

  // Instruction occupying the WB stage; a load's result is ready here.
  typedef struct packed {
    logic      v;
    reg_addr_t dst;
    logic      wr;
  } wb_slot_t;

  localparam slot_t    SLOT_EMPTY    = '0;
  localparam wb_slot_t WB_SLOT_EMPTY = '0;

  // True when a read source matches a live register-writing producer.
  function automatic logic producer_hit(input logic      use_src,
                                        input reg_addr_t src,
                                        input logic      prod_v,
                                        input logic      prod_wr,
                                        input reg_addr_t prod_dst);
    return use_src & prod_v & prod_wr & (src == prod_dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_dep_match.sv
// Dependency match for one ID source operand.
// Compares the source address against the EX and WB slots and returns the
// operand forward select (youngest producer wins) plus a raw EX-match flag
// that the parent uses for load-use detection.
// Ports:
//   src_i       source register address
//   use_i       source is actually read
//   ex_i        EX slot contents
//   wb_i        WB slot contents
//   ex_fwd_en_i EX result may be forwarded this cycle (not during a multiply)
//   sel_o       forward select: FWD_RF / FWD_EX / FWD_WB
//   ex_hit_o    source matches a register-writing EX producer (any kind)
module dep_match
  import hazard_pkg::*;
(
  input  reg_addr_t src_i,
  input  logic      use_i,
  input  slot_t     ex_i,
  input  wb_slot_t  wb_i,
  input  logic      ex_fwd_en_i,
  output fwd_sel_t  sel_o,
  output logic      ex_hit_o
);

  logic wb_hit;

  // A load in EX has no result yet, so it matches but cannot forward.
  always_comb begin
    ex_hit_o = producer_hit(use_i, src_i, ex_i.v, ex_i.wr, ex_i.dst);
    wb_hit   = producer_hit(use_i, src_i, wb_i.v, wb_i.wr, wb_i.dst);
    sel_o    = FWD_RF;
    if (ex_hit_o && !ex_i.ld && ex_fwd_en_i) begin
      sel_o = FWD_EX;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 4-stage IF/ID/EX/WB core.
// Tracks destinations in flight in EX and WB, selects operand forwarding for
// the ID instruction, stalls on load-use, holds EX while a multiply runs and
// drops the ID instruction on a taken branch.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_s1/id_s2         source addresses, id_use1/id_use2 sources read
//   id_dst, id_wr       destination and its write enable
//   id_ld, id_mul       instruction is a load / multi-cycle multiply
//   flush               taken branch resolved in EX
//   stall               hold PC and IF/ID
//   ex_bubble, ex_hold  ID/EX loads a NOP / keeps its contents
//   fwd_a, fwd_b        EX operand selects
//   busy                multiply in progress
// All outputs are combinational from the slot registers and ID inputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W   = 3,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_s1,
  input  logic [REG_W-1:0] id_s2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wr,
  input  logic             id_ld,
  input  logic             id_mul,
  input  logic             flush,
  output logic             stall,
  output logic             ex_bubble,
  output logic             ex_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy
);

  // Counter load value: MULW lasts MUL_LAT-1 cycles, leaving at cnt==1.
  localparam cnt_t MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);

  state_e   state_q, state_d;
  cnt_t     cnt_q,   cnt_d;
  slot_t    ex_q,    ex_d;
  wb_slot_t wb_q,    wb_d;

  reg_addr_t s1_addr;
  reg_addr_t s2_addr;
  slot_t     id_slot;
  fwd_sel_t  sel_a;
  fwd_sel_t  sel_b;
  logic      ex_hit_a;
  logic      ex_hit_b;
  logic      in_run;
  logic      ld_hz;

  assign s1_addr = SLOT_DST_W'(id_s1);
  assign s2_addr = SLOT_DST_W'(id_s2);
  assign id_slot = '{v: id_valid, dst: SLOT_DST_W'(id_dst), wr: id_wr, ld: id_ld};
  assign in_run  = (state_q == RUN);

  dep_match u_dep_a (
    .src_i       (s1_addr),
    .use_i       (id_use1),
    .ex_i        (ex_q),
    .wb_i        (wb_q),
    .ex_fwd_en_i (in_run),
    .sel_o       (sel_a),
    .ex_hit_o    (ex_hit_a)
  );

  dep_match u_dep_b (
    .src_i       (s2_addr),
    .use_i       (id_use2),
    .ex_i        (ex_q),
    .wb_i        (wb_q),
    .ex_fwd_en_i (in_run),
    .sel_o       (sel_b),
    .ex_hit_o    (ex_hit_b)
  );

  // A load in EX whose destination ID reads: its data only exists in WB.
  assign ld_hz = in_run & ex_q.v & ex_q.wr & ex_q.ld & id_valid & (ex_hit_a | ex_hit_b);

  // Next-state and pipeline control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_d      = ex_q;
    wb_d      = wb_q;
    stall     = 1'b0;
    ex_bubble = 1'b0;
    ex_hold   = 1'b0;
    busy      = 1'b0;

    case (state_q)
      RUN: begin
        wb_d = '{v: ex_q.v, dst: ex_q.dst, wr: ex_q.wr};
        if (flush) begin
          // Branch kills ID; a multiply sitting in ID never starts.
          ex_bubble = 1'b1;
          ex_d      = SLOT_EMPTY;
        end else if (ld_hz) begin
          stall     = 1'b1;
          ex_bubble = 1'b1;
          ex_d      = SLOT_EMPTY;
        end else begin
          ex_d = id_slot;
          if (id_valid && id_mul) begin
            state_d = MULW;
            cnt_d   = MUL_CNT_INIT;
          end
        end
      end
      MULW: begin
        // Multiply keeps EX; nothing retires, so WB sees bubbles.
        stall   = 1'b1;
        ex_hold = 1'b1;
        busy    = 1'b1;
        wb_d    = WB_SLOT_EMPTY;
        cnt_d   = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Reset overrides the controls so ID/EX fills with NOPs.
    if (rst) begin
      stall     = 1'b0;
      ex_hold   = 1'b0;
      ex_bubble = 1'b1;
      busy      = 1'b0;
    end
  end

  assign fwd_a = rst ? FWD_RF : sel_a;
  assign fwd_b = rst ? FWD_RF : sel_b;

  // State, counter and slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= SLOT_EMPTY;
      wb_q    <= WB_SLOT_EMPTY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      wb_q    <= wb_d;
    end
  end

endmodule
